// File: rtl/glbl_seq_pkg.sv
// Shared definitions for the global reset sequencer: state encoding and widths.
package glbl_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_FILT = 3'd1,
    ST_ROC  = 3'd2,
    ST_TOC  = 3'd3,
    ST_RUN  = 3'd4,
    ST_SOFT = 3'd5
  } state_e;

endpackage

// File: rtl/glbl_sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module glbl_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/glbl_reset_seq.sv
// Startup/reset sequencer: lock-qualified, cycle-counted GSR/PRLD/GTS release,
// plus a req/ack software-initiated global reset.
module glbl_reset_seq
  import glbl_seq_pkg::*;
#(
  parameter int unsigned ROC_CYCLES = 1000,
  parameter int unsigned TOC_CYCLES = 16,
  parameter int unsigned LOCK_FILT  = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               soft_req,
  output logic               soft_ack,
  output logic               gsr,
  output logic               prld,
  output logic               gts,
  output logic               ready,
  output logic [STATE_W-1:0] state,
  output logic               lock_lost
);

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] ROC_LAST  = CNT_W'(ROC_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOC_LAST  = CNT_W'(TOC_CYCLES - 1);
  localparam bit               HAS_TOC   = (TOC_CYCLES != 0);

  logic             lk;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             pend_q, pend_d;
  logic             lost_q, lost_d;
  logic             ack_q, ack_d;
  logic             gsr_q, gsr_d;
  logic             gts_q, gts_d;
  logic             ready_q, ready_d;
  logic             abort;

  glbl_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  // Next state, counter and status; outputs are derived from the next state so
  // their registers change on the same edge as the state register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    lost_d  = lost_q;
    ack_d   = 1'b0;
    abort   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FILT;
        cnt_d   = '0;
      end
      ST_FILT: begin
        if (!lk) begin
          cnt_d = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = ST_ROC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ROC, ST_SOFT: begin
        if (!lk) begin
          abort = 1'b1;
        end else if (cnt_q == ROC_LAST) begin
          state_d = HAS_TOC ? ST_TOC : ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TOC: begin
        if (!lk) begin
          abort = 1'b1;
        end else if (cnt_q == TOC_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // Lock loss outranks a simultaneous soft request.
        if (!lk) begin
          abort  = 1'b1;
          lost_d = 1'b1;
        end else if (soft_req && armed_q) begin
          state_d = ST_SOFT;
          cnt_d   = '0;
          pend_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = ST_FILT;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end

    // Completing a soft sequence acknowledges it and clears the sticky flag.
    if (pend_q && (state_d == ST_RUN)) begin
      ack_d  = 1'b1;
      pend_d = 1'b0;
      lost_d = 1'b0;
    end

    // Request must drop for a cycle after its ack before it can be taken again.
    armed_d = ack_d ? 1'b0 : (armed_q | ~soft_req);

    gts_d   = (state_d != ST_RUN);
    gsr_d   = (state_d != ST_RUN) && (state_d != ST_TOC);
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      pend_q  <= 1'b0;
      lost_q  <= 1'b0;
      ack_q   <= 1'b0;
      gsr_q   <= 1'b1;
      gts_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      pend_q  <= pend_d;
      lost_q  <= lost_d;
      ack_q   <= ack_d;
      gsr_q   <= gsr_d;
      gts_q   <= gts_d;
      ready_q <= ready_d;
    end
  end

  assign soft_ack  = ack_q;
  assign gsr       = gsr_q;
  assign prld      = gsr_q;
  assign gts       = gts_q;
  assign ready     = ready_q;
  assign state     = state_q;
  assign lock_lost = lost_q;

endmodule

// File: tb/tb_glbl_reset_seq.sv
// Scoreboard bench for glbl_reset_seq: one instance with a TOC phase, one without.
module tb_glbl_reset_seq;
  import glbl_seq_pkg::*;

  typedef struct {
    int unsigned cyc;
    logic [8:0]  v;
    string       tag;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n, pll_locked, soft_req;
  logic soft_ack_a, gsr_a, prld_a, gts_a, ready_a, lock_lost_a;
  logic soft_ack_b, gsr_b, prld_b, gts_b, ready_b, lock_lost_b;
  logic [2:0] state_a, state_b;

  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned t0;
  snap_t q_a[$];
  snap_t q_b[$];
  snap_t e_a, e_b;

  logic [8:0] obs_a, obs_b;
  assign obs_a = {state_a, gsr_a, prld_a, gts_a, ready_a, soft_ack_a, lock_lost_a};
  assign obs_b = {state_b, gsr_b, prld_b, gts_b, ready_b, soft_ack_b, lock_lost_b};

  glbl_reset_seq #(.ROC_CYCLES(10), .TOC_CYCLES(4), .LOCK_FILT(3), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_req(soft_req),
    .soft_ack(soft_ack_a), .gsr(gsr_a), .prld(prld_a), .gts(gts_a),
    .ready(ready_a), .state(state_a), .lock_lost(lock_lost_a)
  );

  glbl_reset_seq #(.ROC_CYCLES(10), .TOC_CYCLES(0), .LOCK_FILT(3), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_req(soft_req),
    .soft_ack(soft_ack_b), .gsr(gsr_b), .prld(prld_b), .gts(gts_b),
    .ready(ready_b), .state(state_b), .lock_lost(lock_lost_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected {state, gsr, prld, gts, ready, soft_ack, lock_lost} for a given state.
  function automatic logic [8:0] exp_vec(input state_e st, input logic ack, input logic ll);
    logic g, t, r;
    case (st)
      ST_TOC:  begin g = 1'b0; t = 1'b1; r = 1'b0; end
      ST_RUN:  begin g = 1'b0; t = 1'b0; r = 1'b1; end
      default: begin g = 1'b1; t = 1'b1; r = 1'b0; end
    endcase
    return {3'(st), g, g, t, r, ack, ll};
  endfunction

  task automatic exp_a(input int unsigned c, input state_e st, input logic ack,
                       input logic ll, input string tag);
    snap_t s;
    s.cyc = c; s.v = exp_vec(st, ack, ll); s.tag = tag;
    q_a.push_back(s);
  endtask

  task automatic exp_b(input int unsigned c, input state_e st, input logic ack,
                       input logic ll, input string tag);
    snap_t s;
    s.cyc = c; s.v = exp_vec(st, ack, ll); s.tag = tag;
    q_b.push_back(s);
  endtask

  // Returns 1ns after the posedge that brings cyc to c.
  task automatic goto(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare due scoreboard entries on the falling edge.
  always @(negedge clk) begin
    while (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
      e_a = q_a.pop_front();
      if (e_a.cyc != cyc) check({e_a.tag, "_missed"}, 32'(cyc), 32'(e_a.cyc));
      else                check(e_a.tag, 32'(obs_a), 32'(e_a.v));
    end
    while (q_b.size() != 0 && q_b[0].cyc <= cyc) begin
      e_b = q_b.pop_front();
      if (e_b.cyc != cyc) check({e_b.tag, "_missed"}, 32'(cyc), 32'(e_b.cyc));
      else                check(e_b.tag, 32'(obs_b), 32'(e_b.v));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; pll_locked = 1'b0; soft_req = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_a", 32'(obs_a), 32'(exp_vec(ST_IDLE, 1'b0, 1'b0)));
    check("rst_b", 32'(obs_b), 32'(exp_vec(ST_IDLE, 1'b0, 1'b0)));
    goto(2);
    rst_n = 1'b1;
    t0 = cyc;

    // Basic bring-up: lock raised after edge 5 -> ROC at 10, gsr falls at 20.
    exp_a(t0+1,  ST_FILT, 0, 0, "t1_filt");
    exp_a(t0+9,  ST_FILT, 0, 0, "t1_filt_end");
    exp_a(t0+10, ST_ROC,  0, 0, "t1_roc");
    exp_a(t0+19, ST_ROC,  0, 0, "t1_roc_end");
    exp_a(t0+20, ST_TOC,  0, 0, "t1_gsr_fall");
    exp_a(t0+23, ST_TOC,  0, 0, "t1_toc_end");
    exp_a(t0+24, ST_RUN,  0, 0, "t1_ready");
    exp_a(t0+30, ST_RUN,  0, 0, "t1_run_hold");
    exp_b(t0+19, ST_ROC,  0, 0, "t1b_roc_end");
    exp_b(t0+20, ST_RUN,  0, 0, "t1b_run");
    goto(t0+5);  pll_locked = 1'b1;
    goto(t0+31);

    rst_n = 1'b0; pll_locked = 1'b0;
    goto(cyc+2);
    rst_n = 1'b1;
    t0 = cyc;

    // Lock glitch in FILT restarts the filter.
    exp_a(t0+8,   ST_FILT, 0, 0, "t2_no_early");
    exp_a(t0+10,  ST_FILT, 0, 0, "t2_filt");
    exp_a(t0+11,  ST_ROC,  0, 0, "t2_roc");
    // Lock drop mid-TOC.
    exp_a(t0+21,  ST_TOC,  0, 0, "t3_toc");
    exp_a(t0+23,  ST_TOC,  0, 0, "t3_toc_late");
    exp_a(t0+24,  ST_FILT, 0, 0, "t3_abort");
    // Relock, then lock loss in RUN.
    exp_a(t0+30,  ST_FILT, 0, 0, "t4_filt");
    exp_a(t0+31,  ST_ROC,  0, 0, "t4_roc");
    exp_a(t0+40,  ST_ROC,  0, 0, "t4_roc_end");
    exp_a(t0+41,  ST_TOC,  0, 0, "t4_toc");
    exp_a(t0+44,  ST_TOC,  0, 0, "t4_toc_end");
    exp_a(t0+45,  ST_RUN,  0, 0, "t4_run");
    exp_a(t0+52,  ST_RUN,  0, 0, "t4_run_hold");
    exp_a(t0+53,  ST_FILT, 0, 1, "t4_lost");
    exp_a(t0+59,  ST_FILT, 0, 1, "t4_refilt");
    exp_a(t0+60,  ST_ROC,  0, 1, "t4_reroc");
    exp_a(t0+70,  ST_TOC,  0, 1, "t4_retoc");
    exp_a(t0+74,  ST_RUN,  0, 1, "t4_relock");
    // Soft reset, hold-off, lock loss during SOFT, re-acceptance.
    exp_a(t0+82,  ST_RUN,  0, 1, "t5_pre");
    exp_a(t0+83,  ST_SOFT, 0, 1, "t5_soft");
    exp_a(t0+92,  ST_SOFT, 0, 1, "t5_soft_end");
    exp_a(t0+93,  ST_TOC,  0, 1, "t5_toc");
    exp_a(t0+96,  ST_TOC,  0, 1, "t5_toc_end");
    exp_a(t0+97,  ST_RUN,  1, 0, "t5_ack");
    exp_a(t0+98,  ST_RUN,  0, 0, "t5_ack_once");
    exp_a(t0+105, ST_RUN,  0, 0, "t5_no_retrig");
    exp_a(t0+108, ST_RUN,  0, 0, "t5_rearm");
    exp_a(t0+109, ST_SOFT, 0, 0, "t5_soft2");
    exp_a(t0+113, ST_SOFT, 0, 0, "t5_soft2_mid");
    exp_a(t0+114, ST_FILT, 0, 0, "t5_soft_abort");
    exp_a(t0+120, ST_FILT, 0, 0, "t5_filt");
    exp_a(t0+121, ST_ROC,  0, 0, "t5_roc");
    exp_a(t0+131, ST_TOC,  0, 0, "t5_toc2");
    exp_a(t0+135, ST_RUN,  0, 0, "t5_no_ack");
    exp_a(t0+136, ST_SOFT, 0, 0, "t5_reaccept");
    exp_a(t0+145, ST_SOFT, 0, 0, "t5_soft3_end");
    exp_a(t0+146, ST_TOC,  0, 0, "t5_toc3");
    exp_a(t0+150, ST_RUN,  1, 0, "t5_ack2");
    exp_a(t0+151, ST_RUN,  0, 0, "t5_ack2_once");
    exp_a(t0+157, ST_RUN,  0, 0, "t5_pre_race");
    exp_a(t0+158, ST_FILT, 0, 1, "t5_lock_wins");
    exp_a(t0+159, ST_FILT, 0, 1, "t5_lock_wins_hold");

    goto(t0+3);   pll_locked = 1'b1;
    goto(t0+5);   pll_locked = 1'b0;
    goto(t0+6);   pll_locked = 1'b1;
    goto(t0+21);  pll_locked = 1'b0;
    goto(t0+26);  pll_locked = 1'b1;
    goto(t0+50);  pll_locked = 1'b0;
    goto(t0+55);  pll_locked = 1'b1;
    goto(t0+82);  soft_req   = 1'b1;
    goto(t0+106); soft_req   = 1'b0;
    goto(t0+108); soft_req   = 1'b1;
    goto(t0+111); pll_locked = 1'b0;
    goto(t0+116); pll_locked = 1'b1;
    goto(t0+151); soft_req   = 1'b0;
    goto(t0+155); pll_locked = 1'b0;
    goto(t0+157); soft_req   = 1'b1;
    goto(t0+160); soft_req   = 1'b0;

    rst_n = 1'b0; pll_locked = 1'b0;
    goto(cyc+2);
    rst_n = 1'b1;
    t0 = cyc;

    // Asynchronous reset mid-ROC, then restart with lock already high.
    exp_a(t0+6, ST_FILT, 0, 0, "t6_filt");
    exp_a(t0+7, ST_ROC,  0, 0, "t6_roc");
    exp_a(t0+9, ST_ROC,  0, 0, "t6_roc_mid");
    exp_b(t0+7, ST_ROC,  0, 0, "t6b_roc");
    exp_b(t0+9, ST_ROC,  0, 0, "t6b_roc_mid");
    goto(t0+2); pll_locked = 1'b1;
    goto(t0+10);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_a", 32'(obs_a), 32'(exp_vec(ST_IDLE, 1'b0, 1'b0)));
    check("t6_async_b", 32'(obs_b), 32'(exp_vec(ST_IDLE, 1'b0, 1'b0)));
    goto(t0+12);
    rst_n = 1'b1;
    t0 = cyc;
    exp_a(t0+1,  ST_FILT, 0, 0, "t6_refilt");
    exp_a(t0+4,  ST_FILT, 0, 0, "t6_filt_end");
    exp_a(t0+5,  ST_ROC,  0, 0, "t6_reroc");
    exp_a(t0+14, ST_ROC,  0, 0, "t6_roc_end");
    exp_a(t0+15, ST_TOC,  0, 0, "t6_toc");
    exp_a(t0+18, ST_TOC,  0, 0, "t6_toc_end");
    exp_a(t0+19, ST_RUN,  0, 0, "t6_run");
    exp_b(t0+14, ST_ROC,  0, 0, "t6b_roc_end");
    exp_b(t0+15, ST_RUN,  0, 0, "t6b_toc0");
    exp_b(t0+19, ST_RUN,  0, 0, "t6b_run_hold");
    goto(t0+22);

    check("q_a_left", 32'(q_a.size()), 32'd0);
    check("q_b_left", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
